// File: rtl/dc_fifo_prog_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray conversion, address width and read-mode constants.
package dc_fifo_pkg;

  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;
  localparam int unsigned PTR_MAX  = 32;

  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Callers zero-extend their AW+1 bit pointers; upper zero bits do not disturb the result.
  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray);
    logic [PTR_MAX-1:0] bin;
    bin[PTR_MAX-1] = gray[PTR_MAX-1];
    for (int unsigned i = 0; i < PTR_MAX - 1; i++) begin
      bin[PTR_MAX-2-i] = bin[PTR_MAX-1-i] ^ gray[PTR_MAX-2-i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/dc_fifo_prog_gray_sync.sv
// Multi-flop synchroniser for a registered Gray-coded pointer crossing into another clock domain.
module gray_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] synced
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], gray};
  end

  assign synced = chain[STAGES-1];

endmodule

// File: rtl/dc_fifo_prog.sv
// Dual-clock FIFO with Gray-pointer crossing, registered flags/counts, programmable thresholds
// and selectable standard or first-word-fall-through read mode.
module dc_fifo_prog
  import dc_fifo_pkg::*;
#(
  parameter  int unsigned DATA_BIT    = 16,
  parameter  int unsigned DATA_DEPTH  = 16,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned FWFT        = FWFT_OFF,
  parameter  int unsigned AFULL_TH    = DATA_DEPTH - 2,
  parameter  int unsigned AEMPTY_TH   = 2,
  localparam int unsigned AW          = addr_width(DATA_DEPTH)
) (
  input  logic                rst_n,
  input  logic                wr_clk,
  input  logic                rd_clk,
  input  logic                wr_en,
  input  logic [DATA_BIT-1:0] wr_data,
  output logic                full,
  output logic                almost_full,
  output logic                overflow,
  output logic [AW:0]         wr_cnt,
  input  logic                rd_en,
  output logic [DATA_BIT-1:0] rd_data,
  output logic                rd_valid,
  output logic                empty,
  output logic                almost_empty,
  output logic                underflow,
  output logic [AW:0]         rd_cnt
);

  localparam int unsigned PW = AW + 1;

  logic [DATA_BIT-1:0] mem [DATA_DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wptr, wptr_gray, rsync_gray;
  logic [PW-1:0] wptr_next, wgray_next, rsync_bin, wr_cnt_next;
  logic          wr_accept;

  always_comb begin
    wr_accept   = wr_en && !full;
    wptr_next   = wptr + PW'(wr_accept);
    wgray_next  = PW'(bin2gray(PTR_MAX'(wptr_next)));
    rsync_bin   = PW'(gray2bin(PTR_MAX'(rsync_gray)));
    wr_cnt_next = wptr_next - rsync_bin;
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= (AFULL_TH == 0);
      overflow    <= 1'b0;
      wr_cnt      <= '0;
    end else begin
      wptr        <= wptr_next;
      wptr_gray   <= wgray_next;
      full        <= (wgray_next == {~rsync_gray[PW-1:PW-2], rsync_gray[PW-3:0]});
      almost_full <= (wr_cnt_next >= PW'(AFULL_TH));
      overflow    <= wr_en && full;
      wr_cnt      <= wr_cnt_next;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_accept) mem[wptr[AW-1:0]] <= wr_data;
  end

  // ---------------- read domain ----------------
  // rptr counts words taken out of the RAM; pop_next counts words released to the
  // consumer, so in FWFT the prefetched word still occupies its slot for the writer.
  logic [PW-1:0] rptr, pop_gray, wsync_gray;
  logic [PW-1:0] wsync_bin, rptr_next, pop_next, rd_cnt_next;
  logic          mem_avail, rd_accept, load, valid_next;

  always_comb begin
    wsync_bin = PW'(gray2bin(PTR_MAX'(wsync_gray)));
    mem_avail = (rptr != wsync_bin);
    if (FWFT == FWFT_ON) begin
      rd_accept  = rd_en && rd_valid;
      load       = mem_avail && (!rd_valid || rd_accept);
      valid_next = load || (rd_valid && !rd_accept);
      rptr_next  = rptr + PW'(load);
      pop_next   = rptr_next - PW'(valid_next);
    end else begin
      rd_accept  = rd_en && !empty;
      load       = rd_accept;
      valid_next = rd_accept;
      rptr_next  = rptr + PW'(rd_accept);
      pop_next   = rptr_next;
    end
    rd_cnt_next = wsync_bin - pop_next;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr         <= '0;
      pop_gray     <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
      rd_cnt       <= '0;
    end else begin
      rptr         <= rptr_next;
      pop_gray     <= PW'(bin2gray(PTR_MAX'(pop_next)));
      rd_valid     <= valid_next;
      empty        <= (FWFT == FWFT_ON) ? !valid_next : (rd_cnt_next == '0);
      almost_empty <= (rd_cnt_next <= PW'(AEMPTY_TH));
      underflow    <= rd_en && empty;
      rd_cnt       <= rd_cnt_next;
      if (load) rd_data <= mem[rptr[AW-1:0]];
    end
  end

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wptr_sync (
    .clk    (rd_clk),
    .rst_n  (rst_n),
    .gray   (wptr_gray),
    .synced (wsync_gray)
  );

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
    .clk    (wr_clk),
    .rst_n  (rst_n),
    .gray   (pop_gray),
    .synced (rsync_gray)
  );

endmodule

// File: tb/tb_dc_fifo_prog.sv
// Bench for dc_fifo_prog: a standard-mode and an FWFT instance, vector table plus directed and random traffic.
`timescale 1ns/1ps
module tb_dc_fifo_prog;

  localparam int unsigned DB = 8;
  localparam int unsigned DD = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned AW = 3;
  localparam int NWORDS = 2500;
  localparam int MAXC   = 20000;

  logic rst_n, wr_clk, rd_clk;
  realtime wr_half = 5.0, rd_half = 5.0;

  logic          wr_en [2];
  logic          rd_en [2];
  logic [DB-1:0] wr_data [2];
  logic [DB-1:0] rd_data [2];
  logic          full [2], almost_full [2], overflow [2];
  logic          rd_valid [2], empty [2], almost_empty [2], underflow [2];
  logic [AW:0]   wr_cnt [2], rd_cnt [2];

  int nvec = 0;
  int nmis = 0;
  logic [DB-1:0] q0 [$];
  logic [DB-1:0] q1 [$];

  dc_fifo_prog #(.DATA_BIT(DB), .DATA_DEPTH(DD), .SYNC_STAGES(SS), .FWFT(0),
                 .AFULL_TH(6), .AEMPTY_TH(2)) dut_std (
    .rst_n(rst_n), .wr_clk(wr_clk), .rd_clk(rd_clk),
    .wr_en(wr_en[0]), .wr_data(wr_data[0]), .full(full[0]), .almost_full(almost_full[0]),
    .overflow(overflow[0]), .wr_cnt(wr_cnt[0]), .rd_en(rd_en[0]), .rd_data(rd_data[0]),
    .rd_valid(rd_valid[0]), .empty(empty[0]), .almost_empty(almost_empty[0]),
    .underflow(underflow[0]), .rd_cnt(rd_cnt[0]));

  dc_fifo_prog #(.DATA_BIT(DB), .DATA_DEPTH(DD), .SYNC_STAGES(SS), .FWFT(1),
                 .AFULL_TH(6), .AEMPTY_TH(2)) dut_fwft (
    .rst_n(rst_n), .wr_clk(wr_clk), .rd_clk(rd_clk),
    .wr_en(wr_en[1]), .wr_data(wr_data[1]), .full(full[1]), .almost_full(almost_full[1]),
    .overflow(overflow[1]), .wr_cnt(wr_cnt[1]), .rd_en(rd_en[1]), .rd_data(rd_data[1]),
    .rd_valid(rd_valid[1]), .empty(empty[1]), .almost_empty(almost_empty[1]),
    .underflow(underflow[1]), .rd_cnt(rd_cnt[1]));

  initial begin
    wr_clk = 1'b0;
    forever #(wr_half) wr_clk = ~wr_clk;
  end
  initial begin
    rd_clk = 1'b0;
    forever #(rd_half) rd_clk = ~rd_clk;
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       chk_wr;
    logic [3:0] wr_cnt;
    logic       full, afull, ovf;
    logic       chk_rd;
    logic [3:0] rd_cnt;
    logic       empty, aempty, valid, udf;
    logic [7:0] data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_check(input int d);
    check($sformatf("d%0d_rst_full", d), 32'(full[d]), 0);
    check($sformatf("d%0d_rst_afull", d), 32'(almost_full[d]), 0);
    check($sformatf("d%0d_rst_ovf", d), 32'(overflow[d]), 0);
    check($sformatf("d%0d_rst_wr_cnt", d), 32'(wr_cnt[d]), 0);
    check($sformatf("d%0d_rst_empty", d), 32'(empty[d]), 1);
    check($sformatf("d%0d_rst_aempty", d), 32'(almost_empty[d]), 1);
    check($sformatf("d%0d_rst_udf", d), 32'(underflow[d]), 0);
    check($sformatf("d%0d_rst_rd_cnt", d), 32'(rd_cnt[d]), 0);
    check($sformatf("d%0d_rst_valid", d), 32'(rd_valid[d]), 0);
    check($sformatf("d%0d_rst_data", d), 32'(rd_data[d]), 0);
  endtask

  task automatic drive_write(input int d, input logic [7:0] data);
    wr_en[d] = 1'b1;
    wr_data[d] = data;
    @(posedge wr_clk);
    #1;
    wr_en[d] = 1'b0;
  endtask

  task automatic writer(input int d, input int n);
    int cnt = 0;
    int cyc = 0;
    logic [7:0] x;
    while (cnt < n && cyc < MAXC) begin
      @(negedge wr_clk);
      cyc++;
      check("rnd_ovf_zero", 32'(overflow[d]), 0);
      check("rnd_wr_cnt_le8", 32'(wr_cnt[d] <= 4'd8), 1);
      if (!full[d] && $urandom_range(7) != 0) begin
        x = 8'($urandom);
        wr_en[d] = 1'b1;
        wr_data[d] = x;
        if (d == 0) q0.push_back(x); else q1.push_back(x);
        cnt++;
      end else begin
        wr_en[d] = 1'b0;
      end
    end
    @(negedge wr_clk);
    wr_en[d] = 1'b0;
    check($sformatf("d%0d_rnd_writes_done", d), 32'(cnt), 32'(n));
  endtask

  task automatic reader_std(input int n);
    int got = 0;
    int cyc = 0;
    logic [7:0] e;
    while (got < n && cyc < MAXC) begin
      @(negedge rd_clk);
      cyc++;
      check("rnd_std_udf_zero", 32'(underflow[0]), 0);
      check("rnd_std_rd_cnt_le8", 32'(rd_cnt[0] <= 4'd8), 1);
      if (rd_valid[0]) begin
        if (q0.size() == 0) check("sb_std_extra_word", 1, 0);
        else begin
          e = q0.pop_front();
          check("sb_std_data", 32'(rd_data[0]), 32'(e));
        end
        got++;
      end
      rd_en[0] = !empty[0] && ($urandom_range(7) != 0);
    end
    rd_en[0] = 1'b0;
    check("d0_rnd_reads_done", 32'(got), 32'(n));
  endtask

  task automatic reader_fwft(input int n);
    int got = 0;
    int cyc = 0;
    logic [7:0] e;
    while (got < n && cyc < MAXC) begin
      @(negedge rd_clk);
      cyc++;
      check("rnd_fwft_udf_zero", 32'(underflow[1]), 0);
      check("rnd_fwft_rd_cnt_le8", 32'(rd_cnt[1] <= 4'd8), 1);
      if (rd_valid[1] && $urandom_range(7) != 0) begin
        if (q1.size() == 0) check("sb_fwft_extra_word", 1, 0);
        else begin
          e = q1.pop_front();
          check("sb_fwft_data", 32'(rd_data[1]), 32'(e));
        end
        rd_en[1] = 1'b1;
        got++;
      end else begin
        rd_en[1] = 1'b0;
      end
    end
    @(negedge rd_clk);
    rd_en[1] = 1'b0;
    check("d1_rnd_reads_done", 32'(got), 32'(n));
  endtask

  initial begin
    vec_t tbl [$];
    vec_t v;
    int n;
    bit found;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_en[d] = 1'b0; rd_en[d] = 1'b0; wr_data[d] = '0;
    end

    // ---- reset state ----
    repeat (3) @(posedge wr_clk);
    #1;
    reset_check(0);
    reset_check(1);
    rst_n = 1'b1;
    @(posedge wr_clk);
    #1;

    // ---- table: fill std FIFO past full, then drain ----
    for (int i = 1; i <= 10; i++) begin
      v = '{default: '0};
      v.wr_en   = (i <= 9);
      v.wr_data = (i <= 8) ? 8'(i) : 8'hFF;
      v.chk_wr  = 1'b1;
      v.wr_cnt  = (i < 8) ? 4'(i) : 4'd8;
      v.full    = (i >= 8);
      v.afull   = (i >= 6);
      v.ovf     = (i == 9);
      tbl.push_back(v);
    end
    for (int i = 0; i < 6; i++) begin
      v = '{default: '0};
      v.chk_rd = (i == 5);
      v.rd_cnt = 4'd8;
      tbl.push_back(v);
    end
    for (int k = 1; k <= 10; k++) begin
      v = '{default: '0};
      v.rd_en  = (k <= 9);
      v.chk_rd = 1'b1;
      v.rd_cnt = (k <= 8) ? 4'(8 - k) : 4'd0;
      v.empty  = (k >= 8);
      v.aempty = (k >= 6);
      v.valid  = (k <= 8);
      v.udf    = (k == 9);
      v.data   = (k <= 8) ? 8'(k) : 8'd8;
      tbl.push_back(v);
    end
    for (int i = 0; i < 6; i++) begin
      v = '{default: '0};
      v.chk_wr = (i == 5);
      tbl.push_back(v);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      wr_en[0] = v.wr_en;
      wr_data[0] = v.wr_data;
      rd_en[0] = v.rd_en;
      @(posedge wr_clk);
      #1;
      if (v.chk_wr) begin
        check($sformatf("tbl%0d_wr_cnt", i), 32'(wr_cnt[0]), 32'(v.wr_cnt));
        check($sformatf("tbl%0d_full", i), 32'(full[0]), 32'(v.full));
        check($sformatf("tbl%0d_afull", i), 32'(almost_full[0]), 32'(v.afull));
        check($sformatf("tbl%0d_ovf", i), 32'(overflow[0]), 32'(v.ovf));
      end
      if (v.chk_rd) begin
        check($sformatf("tbl%0d_rd_cnt", i), 32'(rd_cnt[0]), 32'(v.rd_cnt));
        check($sformatf("tbl%0d_empty", i), 32'(empty[0]), 32'(v.empty));
        check($sformatf("tbl%0d_aempty", i), 32'(almost_empty[0]), 32'(v.aempty));
        check($sformatf("tbl%0d_valid", i), 32'(rd_valid[0]), 32'(v.valid));
        check($sformatf("tbl%0d_udf", i), 32'(underflow[0]), 32'(v.udf));
        check($sformatf("tbl%0d_data", i), 32'(rd_data[0]), 32'(v.data));
      end
    end
    wr_en[0] = 1'b0;
    rd_en[0] = 1'b0;

    // ---- underflow on empty std FIFO, then write-to-empty latency ----
    rd_en[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge rd_clk);
      #1;
      check("udf_held", 32'(underflow[0]), 1);
      check("udf_valid", 32'(rd_valid[0]), 0);
      check("udf_rd_cnt", 32'(rd_cnt[0]), 0);
    end
    rd_en[0] = 1'b0;
    @(posedge rd_clk);
    #1;
    check("udf_release", 32'(underflow[0]), 0);

    drive_write(0, 8'h5A);
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      @(posedge rd_clk);
      #1;
      n++;
      found = !empty[0];
    end
    check("std_empty_latency_ok", 32'(n >= 3 && n <= 4), 1);
    rd_en[0] = 1'b1;
    @(posedge rd_clk);
    #1;
    rd_en[0] = 1'b0;
    check("std_single_valid", 32'(rd_valid[0]), 1);
    check("std_single_data", 32'(rd_data[0]), 32'h5A);
    @(posedge rd_clk);
    #1;
    check("std_single_valid_drop", 32'(rd_valid[0]), 0);
    check("std_single_data_hold", 32'(rd_data[0]), 32'h5A);

    // ---- FWFT: fall-through of a single word, pop to empty ----
    drive_write(1, 8'hA5);
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      @(posedge rd_clk);
      #1;
      n++;
      found = rd_valid[1];
    end
    check("fwft_latency_ok", 32'(n >= 3 && n <= 5), 1);
    check("fwft_data", 32'(rd_data[1]), 32'hA5);
    check("fwft_not_empty", 32'(empty[1]), 0);
    check("fwft_rd_cnt1", 32'(rd_cnt[1]), 1);
    rd_en[1] = 1'b1;
    @(posedge rd_clk);
    #1;
    rd_en[1] = 1'b0;
    check("fwft_pop_empty", 32'(empty[1]), 1);
    check("fwft_pop_rd_cnt", 32'(rd_cnt[1]), 0);
    check("fwft_pop_valid", 32'(rd_valid[1]), 0);
    check("fwft_pop_udf", 32'(underflow[1]), 0);

    // ---- FWFT: back-to-back pops reload in the same edge ----
    for (int i = 0; i < 3; i++) drive_write(1, 8'(8'h31 + i));
    repeat (8) @(posedge rd_clk);
    #1;
    check("fwft_burst_head", 32'(rd_data[1]), 32'h31);
    check("fwft_burst_cnt", 32'(rd_cnt[1]), 3);
    rd_en[1] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge rd_clk);
      #1;
      check("fwft_burst_valid", 32'(rd_valid[1]), 32'(i < 3));
      if (i < 3) check("fwft_burst_data", 32'(rd_data[1]), 32'(8'h31 + i));
    end
    rd_en[1] = 1'b0;

    // ---- random traffic, both clock ratios ----
    for (int cfg = 0; cfg < 2; cfg++) begin
      rst_n = 1'b0;
      wr_half = (cfg == 0) ? 5.0 : 13.5;
      rd_half = (cfg == 0) ? 13.5 : 5.0;
      q0.delete();
      q1.delete();
      #60;
      rst_n = 1'b1;
      #30;
      fork
        writer(0, NWORDS);
        reader_std(NWORDS);
        writer(1, NWORDS);
        reader_fwft(NWORDS);
      join
      check("sb_std_leftover", 32'(q0.size()), 0);
      check("sb_fwft_leftover", 32'(q1.size()), 0);
    end

    // ---- reset mid-burst with 5 words stored ----
    wr_half = 5.0;
    rd_half = 5.0;
    @(posedge wr_clk);
    #1;
    for (int i = 1; i <= 5; i++) drive_write(0, 8'(8'h40 + i));
    repeat (6) @(posedge rd_clk);
    rd_en[0] = 1'b1;
    @(posedge rd_clk);
    #2;
    rd_en[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_check(0);
    reset_check(1);
    #10;
    rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
    drive_write(0, 8'h11);
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      @(posedge rd_clk);
      #1;
      n++;
      found = !empty[0];
    end
    check("rst_write_visible", 32'(found), 1);
    rd_en[0] = 1'b1;
    @(posedge rd_clk);
    #1;
    rd_en[0] = 1'b0;
    check("rst_first_valid", 32'(rd_valid[0]), 1);
    check("rst_first_data", 32'(rd_data[0]), 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
